// File: rtl/key_sched_rcon_gen.sv
// key_sched_rcon_gen: AES-128/192/256 key-expansion word sequencer.
// Walks word index i from Nk up to 4*(Nr+1)-1, one word per adv, and
// tells the datapath which words need RotWord/SubWord and which Rcon to use.
module key_sched_rcon_gen #(
  parameter int         RC_W    = 32,
  parameter logic [7:0] POLY    = 8'h1B,
  parameter logic [7:0] RC_INIT = 8'h01,
  parameter int         IDX_W   = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             adv,
  output logic [RC_W-1:0]  rc,
  output logic             rot_sub,
  output logic             sub_only,
  output logic [IDX_W-1:0] word_idx,
  output logic             busy,
  output logic             done,
  output logic             mode_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [1:0] M_128 = 2'd0;
  localparam logic [1:0] M_192 = 2'd1;
  localparam logic [1:0] M_256 = 2'd2;
  localparam logic [1:0] M_BAD = 2'd3;

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [2:0]       kmod_q, kmod_d;      // i mod Nk, Nk<=8
  logic [7:0]       rcon_q, rcon_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic             rot_sub_q, rot_sub_d;
  logic             sub_only_q, sub_only_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mode_err_q, mode_err_d;
  logic [7:0]       rcon_nxt;

  // GF(2^8) multiply-by-x with reduction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
  endfunction

  // Rcon byte placed in the top byte, remainder zero
  function automatic logic [RC_W-1:0] rc_word(input logic [7:0] b);
    logic [RC_W-1:0] r;
    r = '0;
    r[RC_W-1 -: 8] = b;
    rc_word = r;
  endfunction

  // Nk-1 per mode: the kmod value on which the next word wraps to 0
  function automatic logic [2:0] nk_m1(input logic [1:0] m);
    case (m)
      M_192:   nk_m1 = 3'd5;
      M_256:   nk_m1 = 3'd7;
      default: nk_m1 = 3'd3;
    endcase
  endfunction

  // First word index produced (i = Nk)
  function automatic logic [IDX_W-1:0] first_idx(input logic [1:0] m);
    case (m)
      M_192:   first_idx = IDX_W'(6);
      M_256:   first_idx = IDX_W'(8);
      default: first_idx = IDX_W'(4);
    endcase
  endfunction

  // Last word index 4*(Nr+1)-1
  function automatic logic [IDX_W-1:0] last_idx(input logic [1:0] m);
    case (m)
      M_192:   last_idx = IDX_W'(51);
      M_256:   last_idx = IDX_W'(59);
      default: last_idx = IDX_W'(43);
    endcase
  endfunction

  assign rcon_nxt = xtime(rcon_q);

  // Next-state and registered-output computation; everything holds by default
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    kmod_d     = kmod_q;
    rcon_d     = rcon_q;
    word_idx_d = word_idx_q;
    rc_d       = rc_q;
    rot_sub_d  = rot_sub_q;
    sub_only_d = sub_only_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mode_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        // adv is meaningless here; start alone decides
        if (start) begin
          if (mode == M_BAD) begin
            mode_err_d = 1'b1;
          end else begin
            state_d    = S_RUN;
            mode_d     = mode;
            word_idx_d = first_idx(mode);
            kmod_d     = 3'd0;
            rcon_d     = RC_INIT;
            busy_d     = 1'b1;
            rot_sub_d  = 1'b1;
            sub_only_d = 1'b0;
            rc_d       = rc_word(RC_INIT);
          end
        end
      end

      S_RUN: begin
        // start is ignored mid-schedule; without adv every output holds
        if (adv) begin
          if (word_idx_q == last_idx(mode_q)) begin
            state_d    = S_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            rc_d       = '0;
            rot_sub_d  = 1'b0;
            sub_only_d = 1'b0;
            word_idx_d = '0;
            kmod_d     = 3'd0;
          end else begin
            word_idx_d = word_idx_q + IDX_W'(1);
            if (kmod_q == nk_m1(mode_q)) begin
              // start of a new Nk group: advance Rcon and present it
              kmod_d     = 3'd0;
              rcon_d     = rcon_nxt;
              rot_sub_d  = 1'b1;
              sub_only_d = 1'b0;
              rc_d       = rc_word(rcon_nxt);
            end else begin
              kmod_d     = kmod_q + 3'd1;
              rot_sub_d  = 1'b0;
              rc_d       = '0;
              // AES-256 mid-group word (kmod becomes 4) needs SubWord only
              sub_only_d = (mode_q == M_256) && (kmod_q == 3'd3);
            end
          end
        end
      end

      S_DONE: begin
        // one-cycle done pulse, then back to idle regardless of inputs
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      mode_q     <= M_128;
      kmod_q     <= 3'd0;
      rcon_q     <= RC_INIT;
      word_idx_q <= '0;
      rc_q       <= '0;
      rot_sub_q  <= 1'b0;
      sub_only_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      kmod_q     <= kmod_d;
      rcon_q     <= rcon_d;
      word_idx_q <= word_idx_d;
      rc_q       <= rc_d;
      rot_sub_q  <= rot_sub_d;
      sub_only_q <= sub_only_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mode_err_q <= mode_err_d;
    end
  end

  assign rc       = rc_q;
  assign rot_sub  = rot_sub_q;
  assign sub_only = sub_only_q;
  assign word_idx = word_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mode_err = mode_err_q;

endmodule

// File: tb/tb_key_sched_rcon_gen.sv
// Bench for key_sched_rcon_gen: directed schedules in all three key sizes,
// compared every cycle against a word-index model plus literal expectations.
module tb_key_sched_rcon_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  mode;
  logic        adv;
  logic [31:0] rc;
  logic        rot_sub, sub_only, busy, done, mode_err;
  logic [5:0]  word_idx;

  int checks   = 0;
  int failures = 0;

  key_sched_rcon_gen dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .adv(adv),
    .rc(rc), .rot_sub(rot_sub), .sub_only(sub_only), .word_idx(word_idx),
    .busy(busy), .done(done), .mode_err(mode_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 walking words, 2 done pulse
  int m_phase = 0;
  int m_i     = 0;
  int m_nk    = 4;
  int m_last  = 43;
  bit m_err   = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0;
      m_i     <= 0;
      m_err   <= 1'b0;
    end else begin
      m_err <= 1'b0;
      case (m_phase)
        0: if (start) begin
          if (mode == 2'd3) m_err <= 1'b1;
          else begin
            m_nk    <= 4 + 2 * int'(mode);
            m_last  <= 4 * (10 + 2 * int'(mode) + 1) - 1;
            m_i     <= 4 + 2 * int'(mode);
            m_phase <= 1;
          end
        end
        1: if (adv) begin
          if (m_i == m_last) m_phase <= 2;
          else m_i <= m_i + 1;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // x^n in GF(2^8) modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_pow_x(input int n);
    logic [8:0] v;
    v = 9'h001;
    for (int k = 0; k < n; k++) begin
      v = v << 1;
      if (v[8]) v = v ^ 9'h11B;
    end
    return v[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] e_rc;
    bit e_rot, e_sub, e_busy, e_done;
    int e_idx;
    e_rc = 0; e_rot = 0; e_sub = 0; e_busy = 0; e_done = 0; e_idx = 0;
    if (m_phase == 1) begin
      e_busy = 1;
      e_idx  = m_i;
      e_rot  = (m_i % m_nk) == 0;
      e_sub  = (m_nk == 8) && ((m_i % m_nk) == 4);
      if (e_rot) e_rc = {gf_pow_x(m_i / m_nk - 1), 24'h0};
    end else if (m_phase == 2) begin
      e_done = 1;
    end
    chk("word_idx", 32'(word_idx), 32'(e_idx));
    chk("rc",       rc,            e_rc);
    chk("rot_sub",  32'(rot_sub),  32'(e_rot));
    chk("sub_only", 32'(sub_only), 32'(e_sub));
    chk("busy",     32'(busy),     32'(e_busy));
    chk("done",     32'(done),     32'(e_done));
    chk("mode_err", 32'(mode_err), 32'(m_err));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // ---------------- literal expectations ----------------
  logic [7:0] rc128 [10] = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1B,8'h36};
  logic [7:0] rc192 [8]  = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80};
  logic [7:0] rc256 [7]  = '{8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40};

  logic [7:0] rc_log [$];

  // One schedule: start, adv every cycle (with optional stall / restart / reset)
  task automatic run(input logic [1:0] m, input int stall_i, input int restart_i,
                     input int reset_i, input int exp_last, input int exp_adv,
                     input int exp_sub);
    int  cyc, n_adv, n_sub, last_i;
    bit  stalled, did_reset;
    rc_log.delete();
    n_adv = 0; n_sub = 0; last_i = -1; stalled = 0; did_reset = 0; cyc = 0;
    start = 1'b1; mode = m; adv = 1'b0;
    tick();
    start = 1'b0;
    chk("first_idx", 32'(word_idx), 32'(4 + 2 * int'(m)));
    chk("first_rc",  rc, 32'h0100_0000);
    while (!done && cyc < 200 && !did_reset) begin
      if (busy && rot_sub) rc_log.push_back(rc[31:24]);
      if (busy && sub_only) n_sub++;
      if (int'(word_idx) == reset_i) begin
        #3 reset_n = 1'b0;
        #1;
        check_model();
        chk("rst_idx",  32'(word_idx), 32'h0);
        chk("rst_busy", 32'(busy),     32'h0);
        chk("rst_rc",   rc,            32'h0);
        #2 reset_n = 1'b1;
        did_reset = 1;
      end else begin
        if (int'(word_idx) == stall_i && !stalled) begin
          stalled = 1;
          adv = 1'b0;
          repeat (5) begin
            tick();
            chk("stall_idx",  32'(word_idx), 32'd8);
            chk("stall_rc",   rc,            32'h0200_0000);
            chk("stall_busy", 32'(busy),     32'h1);
          end
        end
        adv = 1'b1;
        if (int'(word_idx) == restart_i) begin start = 1'b1; mode = 2'd0; end
        last_i = int'(word_idx);
        tick();
        n_adv++; cyc++;
        adv = 1'b0; start = 1'b0;
      end
    end
    if (did_reset) return;
    chk("done_seen", 32'(done), 32'h1);
    chk("last_idx", 32'(last_i), 32'(exp_last));
    chk("adv_count", 32'(n_adv), 32'(exp_adv));
    chk("sub_count", 32'(n_sub), 32'(exp_sub));
    chk("rc_count", 32'(rc_log.size()), 32'(m == 2'd0 ? 10 : (m == 2'd1 ? 8 : 7)));
    foreach (rc_log[k]) begin
      if (m == 2'd0 && k < 10) chk("rc128_seq", 32'(rc_log[k]), 32'(rc128[k]));
      if (m == 2'd1 && k < 8)  chk("rc192_seq", 32'(rc_log[k]), 32'(rc192[k]));
      if (m == 2'd2 && k < 7)  chk("rc256_seq", 32'(rc_log[k]), 32'(rc256[k]));
    end
    // start during the done pulse must be ignored
    start = 1'b1; mode = 2'd0;
    tick();
    start = 1'b0;
    chk("post_done_busy", 32'(busy), 32'h0);
    chk("post_done_pulse", 32'(done), 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; mode = 2'd0; adv = 1'b0;
    #2;
    check_model();
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_rc",   rc,        32'h0);
    @(posedge clk); #3 reset_n = 1'b1;

    // adv while idle does nothing
    adv = 1'b1;
    tick(); tick();
    chk("idle_adv_busy", 32'(busy), 32'h0);
    adv = 1'b0;

    run(2'd0, -1, -1, -1, 43, 40, 0);   // AES-128 straight through
    run(2'd2, -1, -1, -1, 59, 52, 6);   // AES-256
    run(2'd1, -1, 10, -1, 51, 46, 0);   // AES-192 with ignored restart at i=10
    run(2'd0,  8, -1, -1, 43, 40, 0);   // AES-128 with 5-cycle stall at i=8

    // illegal mode
    start = 1'b1; mode = 2'd3;
    tick();
    start = 1'b0;
    chk("mode_err_pulse", 32'(mode_err), 32'h1);
    chk("mode_err_busy",  32'(busy),     32'h0);
    tick();
    chk("mode_err_clear", 32'(mode_err), 32'h0);

    // async reset mid AES-256, then a fresh AES-128 run
    run(2'd2, -1, -1, 20, 0, 0, 0);
    tick();
    run(2'd0, -1, -1, -1, 43, 40, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
